// File: rtl/audio_mixer_pkg.sv
// Shared types, saturation limits and width helper for the audio mixer.
package audio_mixer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DC,
        OUT
    } state_t;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    // 16x5-bit signed products are 21 bits; each doubling of sources adds one guard bit.
    function automatic int acc_width(input int num_src);
        return 21 + $clog2(num_src);
    endfunction

endpackage

// File: rtl/audio_mixer_if.sv
// Source-side bundle of the mixer: sample streams and volumes in, mixed sample out.
interface audio_mixer_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC*16-1:0] src_in;
    logic [NUM_SRC*4-1:0]  src_vol;
    logic                  dc_en;
    logic signed [15:0]    sound_out;
    logic                  sample_valid;
    logic                  clip;

    modport master (
        output src_in, src_vol, dc_en,
        input  sound_out, sample_valid, clip
    );

    modport slave (
        input  src_in, src_vol, dc_en,
        output sound_out, sample_valid, clip
    );
endinterface

// File: rtl/audio_mixer_dc_blocker.sv
// One-pole DC-blocking high-pass filter with its own history registers.
// The feedback state carries DC_SHIFT fractional bits so small residues keep draining.
module dc_blocker #(
    parameter int X_W      = 23,
    parameter int DC_SHIFT = 10
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic signed [X_W-1:0]           x,
    input  logic                            load,
    input  logic                            clear,
    output logic signed [X_W+DC_SHIFT-1:0]  y
);
    localparam int Y_W = X_W + DC_SHIFT;

    logic signed [X_W-1:0] x_prev_q, x_prev_d;
    logic signed [Y_W-1:0] y_prev_q, y_prev_d;
    logic signed [Y_W-1:0] step;
    logic signed [Y_W-1:0] y_state;

    always_comb begin
        step     = Y_W'(x) - Y_W'(x_prev_q);
        y_state  = (step <<< DC_SHIFT) + y_prev_q - (y_prev_q >>> DC_SHIFT);
        y        = y_state >>> DC_SHIFT;
        x_prev_d = x_prev_q;
        y_prev_d = y_prev_q;
        if (clear) begin
            x_prev_d = '0;
            y_prev_d = '0;
        end else if (load) begin
            x_prev_d = x;
            y_prev_d = y_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
        end else begin
            x_prev_q <= x_prev_d;
            y_prev_q <= y_prev_d;
        end
    end

endmodule

// File: rtl/audio_mixer.sv
// Sample-rate mixer: snapshots all sources on each divider tick, scales them by
// per-source volume through one shared MAC, optionally DC-blocks, then saturates.
module audio_mixer
    import audio_mixer_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int SAMPLE_DIV = 448,
    parameter int DC_SHIFT   = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    audio_mixer_if.slave bus
);
    localparam int ACC_W = acc_width(NUM_SRC);
    localparam int Y_W   = ACC_W + DC_SHIFT;
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic signed [Y_W-1:0] Y_MAX = Y_W'(SAT_MAX);
    localparam logic signed [Y_W-1:0] Y_MIN = Y_W'(SAT_MIN);

    if (SAMPLE_DIV < NUM_SRC + 4 || NUM_SRC < 1 || NUM_SRC > 8) begin : g_param_check
        $error("audio_mixer: need 1 <= NUM_SRC <= 8 and SAMPLE_DIV >= NUM_SRC+4");
    end

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tick;
    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [Y_W-1:0] y_q, y_d;
    logic signed [15:0]    snap_src_q [NUM_SRC];
    logic signed [15:0]    snap_src_d [NUM_SRC];
    logic [3:0]            snap_vol_q [NUM_SRC];
    logic [3:0]            snap_vol_d [NUM_SRC];
    logic signed [15:0]    sound_out_q, sound_out_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  clip_q, clip_d;

    logic signed [15:0]    cur_src;
    logic signed [4:0]     cur_vol;
    logic signed [20:0]    prod;
    logic signed [ACC_W-1:0] x_dc;
    logic signed [Y_W-1:0] y_hp;
    logic                  dc_load;
    logic                  dc_clear;

    // Free-running divider; it never waits on the FSM.
    always_comb begin
        tick  = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        cur_src = snap_src_q[idx_q];
        cur_vol = $signed({1'b0, snap_vol_q[idx_q]});
        prod    = 21'(cur_src) * 21'(cur_vol);
        x_dc    = acc_q >>> 3;
    end

    dc_blocker #(
        .X_W      (ACC_W),
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_blocker (
        .clk     (clk),
        .reset_n (reset_n),
        .x       (x_dc),
        .load    (dc_load),
        .clear   (dc_clear),
        .y       (y_hp)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        y_d            = y_q;
        snap_src_d     = snap_src_q;
        snap_vol_d     = snap_vol_q;
        sound_out_d    = sound_out_q;
        clip_d         = clip_q;
        sample_valid_d = 1'b0;
        dc_load        = 1'b0;
        dc_clear       = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        snap_src_d[i] = bus.src_in[16*i +: 16];
                        snap_vol_d[i] = bus.src_vol[4*i +: 4];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (idx_q == IDX_W'(NUM_SRC - 1)) begin
                    state_d = DC;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DC: begin
                // Bypassing the filter also wipes its history so re-enabling starts clean.
                if (bus.dc_en) begin
                    y_d     = y_hp;
                    dc_load = 1'b1;
                end else begin
                    y_d      = Y_W'(x_dc);
                    dc_clear = 1'b1;
                end
                state_d = OUT;
            end
            OUT: begin
                if (y_q > Y_MAX) begin
                    sound_out_d = SAT_MAX;
                    clip_d      = 1'b1;
                end else if (y_q < Y_MIN) begin
                    sound_out_d = SAT_MIN;
                    clip_d      = 1'b1;
                end else begin
                    sound_out_d = y_q[15:0];
                    clip_d      = 1'b0;
                end
                sample_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q          <= '0;
            state_q        <= IDLE;
            idx_q          <= '0;
            acc_q          <= '0;
            y_q            <= '0;
            snap_src_q     <= '{default: '0};
            snap_vol_q     <= '{default: '0};
            sound_out_q    <= '0;
            sample_valid_q <= 1'b0;
            clip_q         <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            state_q        <= state_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            y_q            <= y_d;
            snap_src_q     <= snap_src_d;
            snap_vol_q     <= snap_vol_d;
            sound_out_q    <= sound_out_d;
            sample_valid_q <= sample_valid_d;
            clip_q         <= clip_d;
        end
    end

    assign bus.sound_out    = sound_out_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.clip         = clip_q;

endmodule
